// File: rtl/dmem_arbiter_if.sv
// Bundle of requester handshakes and the shared memory port seen by dmem_arbiter.
// slave = arbiter side, master = requester/memory environment side.
interface dmem_arbiter_if;
  logic        i_req_0;
  logic        i_we_0;
  logic [2:0]  i_fun3_0;
  logic [31:0] i_addr_0;
  logic [31:0] i_wdata_0;
  logic        o_gnt_0;
  logic        o_rvalid_0;
  logic [31:0] o_rdata_0;
  logic        o_err_0;

  logic        i_req_1;
  logic        i_we_1;
  logic [2:0]  i_fun3_1;
  logic [31:0] i_addr_1;
  logic [31:0] i_wdata_1;
  logic        o_gnt_1;
  logic        o_rvalid_1;
  logic [31:0] o_rdata_1;
  logic        o_err_1;

  logic        o_mem_rd_en;
  logic        o_mem_wr_en;
  logic [2:0]  o_mem_fun3;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_req_0, i_we_0, i_fun3_0, i_addr_0, i_wdata_0,
    input  i_req_1, i_we_1, i_fun3_1, i_addr_1, i_wdata_1,
    input  i_mem_rdata,
    output o_gnt_0, o_rvalid_0, o_rdata_0, o_err_0,
    output o_gnt_1, o_rvalid_1, o_rdata_1, o_err_1,
    output o_mem_rd_en, o_mem_wr_en, o_mem_fun3, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_req_0, i_we_0, i_fun3_0, i_addr_0, i_wdata_0,
    output i_req_1, i_we_1, i_fun3_1, i_addr_1, i_wdata_1,
    output i_mem_rdata,
    input  o_gnt_0, o_rvalid_0, o_rdata_0, o_err_0,
    input  o_gnt_1, o_rvalid_1, o_rdata_1, o_err_1,
    input  o_mem_rd_en, o_mem_wr_en, o_mem_fun3, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and legality checker in front of the data memory.
// Port 0 has fixed priority; a saturating wait counter force-grants port 1.
module dmem_arbiter #(
  parameter int unsigned DEPTH_WORDS  = 512,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  dmem_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W      = 8;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             gnt_0;
  logic             gnt_1;
  logic             accept;
  logic             legal;
  logic             fun3_ok;
  logic             align_ok;
  logic             range_ok;
  logic             sel_we;
  logic [2:0]       sel_fun3;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [31:0]      resp_rdata;

  logic             rvalid_0;
  logic             rvalid_1;
  logic             err_0;
  logic             err_1;
  logic [31:0]      rdata_0;
  logic [31:0]      rdata_1;

  // Grant: starved port 1 first, then port 0, then port 1; nothing in reset.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (!i_rst) begin
      if ((starve_cnt == STARVE_MAX) && bus.i_req_1) gnt_1 = 1'b1;
      else if (bus.i_req_0)                          gnt_0 = 1'b1;
      else if (bus.i_req_1)                          gnt_1 = 1'b1;
    end
  end

  assign accept      = gnt_0 | gnt_1;
  assign bus.o_gnt_0 = gnt_0;
  assign bus.o_gnt_1 = gnt_1;

  always_comb begin
    if (gnt_1) begin
      sel_we    = bus.i_we_1;
      sel_fun3  = bus.i_fun3_1;
      sel_addr  = bus.i_addr_1;
      sel_wdata = bus.i_wdata_1;
    end else begin
      sel_we    = bus.i_we_0;
      sel_fun3  = bus.i_fun3_0;
      sel_addr  = bus.i_addr_0;
      sel_wdata = bus.i_wdata_0;
    end
  end

  // Legality of the winning payload: funct3 class, natural alignment, range.
  always_comb begin
    fun3_ok  = 1'b0;
    align_ok = 1'b1;
    case (sel_fun3)
      3'b000, 3'b001, 3'b010: fun3_ok = 1'b1;
      3'b100, 3'b101:         fun3_ok = !sel_we;
      default:                fun3_ok = 1'b0;
    endcase
    if (sel_fun3[1:0] == 2'b01)      align_ok = !sel_addr[0];
    else if (sel_fun3[1:0] == 2'b10) align_ok = (sel_addr[1:0] == 2'b00);
    range_ok = (sel_addr < ADDR_LIMIT);
    legal    = fun3_ok && align_ok && range_ok;
  end

  always_comb begin
    bus.o_mem_rd_en = 1'b0;
    bus.o_mem_wr_en = 1'b0;
    bus.o_mem_fun3  = 3'b000;
    bus.o_mem_addr  = 32'h0;
    bus.o_mem_wdata = 32'h0;
    if (accept && legal) begin
      bus.o_mem_rd_en = !sel_we;
      bus.o_mem_wr_en = sel_we;
      bus.o_mem_fun3  = sel_fun3;
      bus.o_mem_addr  = sel_addr;
      bus.o_mem_wdata = sel_wdata;
    end
  end

  assign resp_rdata = (legal && !sel_we) ? bus.i_mem_rdata : 32'h0;

  // Wait counter only runs while port 1 is actually being refused.
  always_ff @(posedge i_clk) begin
    if (i_rst || !bus.i_req_1 || gnt_1) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      err_0    <= 1'b0;
      err_1    <= 1'b0;
      rdata_0  <= 32'h0;
      rdata_1  <= 32'h0;
    end else begin
      rvalid_0 <= gnt_0;
      rvalid_1 <= gnt_1;
      if (gnt_0) begin
        err_0   <= !legal;
        rdata_0 <= resp_rdata;
      end
      if (gnt_1) begin
        err_1   <= !legal;
        rdata_1 <= resp_rdata;
      end
    end
  end

  assign bus.o_rvalid_0 = rvalid_0;
  assign bus.o_rvalid_1 = rvalid_1;
  assign bus.o_err_0    = err_0;
  assign bus.o_err_1    = err_1;
  assign bus.o_rdata_0  = rdata_0;
  assign bus.o_rdata_1  = rdata_1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory, rule-level reference model checked
// every negedge, plus directed literal expectations pinned per cycle.
module tb_dmem_arbiter;
  localparam int unsigned DEPTH_WORDS  = 512;
  localparam int unsigned STARVE_LIMIT = 8;
  localparam int unsigned MEM_BYTES    = 4 * DEPTH_WORDS;
  localparam int unsigned MAX_PINS     = 6;

  typedef enum int {S_GNT0, S_GNT1, S_RV0, S_RV1, S_RD0, S_RD1,
                    S_ERR0, S_ERR1, S_RDEN, S_WREN, S_FUN3} sig_e;

  logic clk = 1'b0;
  logic rst;

  dmem_arbiter_if bus();

  dmem_arbiter #(.DEPTH_WORDS(DEPTH_WORDS), .STARVE_LIMIT(STARVE_LIMIT)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [MEM_BYTES];
  int n_checks = 0;
  int n_fail   = 0;

  int          pin_cnt = 0;
  sig_e        pin_sig  [MAX_PINS];
  logic [31:0] pin_val  [MAX_PINS];
  string       pin_name [MAX_PINS];

  // Little-endian read with RV32I sign/zero extension.
  function automatic logic [31:0] mread(logic [2:0] f, logic [31:0] a);
    logic [10:0] i;
    logic [31:0] w;
    i = a[10:0];
    w = {mem[11'(i + 3)], mem[11'(i + 2)], mem[11'(i + 1)], mem[i]};
    case (f)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  always_comb bus.i_mem_rdata = mread(bus.o_mem_fun3, bus.o_mem_addr);

  function automatic bit is_legal(logic we, logic [2:0] f, logic [31:0] a);
    bit          fok;
    int unsigned sz;
    fok = we ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
    sz  = 1 << f[1:0];
    return fok && ((a % sz) == 0) && (a < MEM_BYTES);
  endfunction

  function automatic logic [31:0] sig(sig_e s);
    case (s)
      S_GNT0:  return 32'(bus.o_gnt_0);
      S_GNT1:  return 32'(bus.o_gnt_1);
      S_RV0:   return 32'(bus.o_rvalid_0);
      S_RV1:   return 32'(bus.o_rvalid_1);
      S_RD0:   return bus.o_rdata_0;
      S_RD1:   return bus.o_rdata_1;
      S_ERR0:  return 32'(bus.o_err_0);
      S_ERR1:  return 32'(bus.o_err_1);
      S_RDEN:  return 32'(bus.o_mem_rd_en);
      S_WREN:  return 32'(bus.o_mem_wr_en);
      default: return 32'(bus.o_mem_fun3);
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: expected registered outputs and port-1 refusal count.
  logic        e_rv0 = 1'b0, e_rv1 = 1'b0, e_err0 = 1'b0, e_err1 = 1'b0;
  logic [31:0] e_rd0 = 32'h0, e_rd1 = 32'h0;
  bit          primed = 1'b0;
  int unsigned denied = 0;

  always @(negedge clk) begin
    bit          eg0, eg1, lg, p_we;
    logic [2:0]  p_f;
    logic [31:0] p_a, p_d, nrd;
    int unsigned nb;
    if (primed) begin
      chk("rvalid_0", 32'(bus.o_rvalid_0), 32'(e_rv0));
      chk("rvalid_1", 32'(bus.o_rvalid_1), 32'(e_rv1));
      chk("rdata_0", bus.o_rdata_0, e_rd0);
      chk("rdata_1", bus.o_rdata_1, e_rd1);
      if (e_rv0) chk("err_0", 32'(bus.o_err_0), 32'(e_err0));
      if (e_rv1) chk("err_1", 32'(bus.o_err_1), 32'(e_err1));
    end
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!rst) begin
      if (denied == STARVE_LIMIT && bus.i_req_1) eg1 = 1'b1;
      else if (bus.i_req_0)                      eg0 = 1'b1;
      else if (bus.i_req_1)                      eg1 = 1'b1;
    end
    chk("gnt_0", 32'(bus.o_gnt_0), 32'(eg0));
    chk("gnt_1", 32'(bus.o_gnt_1), 32'(eg1));
    p_we = eg1 ? bus.i_we_1    : bus.i_we_0;
    p_f  = eg1 ? bus.i_fun3_1  : bus.i_fun3_0;
    p_a  = eg1 ? bus.i_addr_1  : bus.i_addr_0;
    p_d  = eg1 ? bus.i_wdata_1 : bus.i_wdata_0;
    lg   = (eg0 || eg1) && is_legal(p_we, p_f, p_a);
    chk("mem_rd_en", 32'(bus.o_mem_rd_en), 32'(lg && !p_we));
    chk("mem_wr_en", 32'(bus.o_mem_wr_en), 32'(lg && p_we));
    chk("mem_fun3", 32'(bus.o_mem_fun3), lg ? 32'(p_f) : 32'h0);
    chk("mem_addr", bus.o_mem_addr, lg ? p_a : 32'h0);
    chk("mem_wdata", bus.o_mem_wdata, lg ? p_d : 32'h0);
    for (int k = 0; k < pin_cnt; k++) chk(pin_name[k], sig(pin_sig[k]), pin_val[k]);

    nrd = (lg && !p_we) ? mread(p_f, p_a) : 32'h0;
    if (rst) begin
      e_rv0 = 1'b0; e_rv1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
      e_rd0 = 32'h0; e_rd1 = 32'h0;
    end else begin
      e_rv0 = eg0;
      e_rv1 = eg1;
      if (eg0) begin e_err0 = !lg; e_rd0 = nrd; end
      if (eg1) begin e_err1 = !lg; e_rd1 = nrd; end
    end
    if (rst || !bus.i_req_1 || eg1) denied = 0;
    else if (denied < STARVE_LIMIT)  denied++;
    // Memory commits whatever store the DUT presents at this edge.
    if (bus.o_mem_wr_en) begin
      nb = 1 << bus.o_mem_fun3[1:0];
      if (nb > 4) nb = 4;
      for (int b = 0; b < int'(nb); b++)
        mem[11'(bus.o_mem_addr[10:0] + 11'(b))] = bus.o_mem_wdata[8*b +: 8];
    end
    if (rst) primed = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
    pin_cnt = 0;
  endtask

  task automatic pin(string n, sig_e s, logic [31:0] v);
    if (pin_cnt < MAX_PINS) begin
      pin_name[pin_cnt] = n;
      pin_sig[pin_cnt]  = s;
      pin_val[pin_cnt]  = v;
      pin_cnt++;
    end
  endtask

  task automatic p0(logic req, logic we, logic [2:0] f, logic [31:0] a, logic [31:0] d);
    bus.i_req_0 = req; bus.i_we_0 = we; bus.i_fun3_0 = f; bus.i_addr_0 = a; bus.i_wdata_0 = d;
  endtask

  task automatic p1(logic req, logic we, logic [2:0] f, logic [31:0] a, logic [31:0] d);
    bus.i_req_1 = req; bus.i_we_1 = we; bus.i_fun3_1 = f; bus.i_addr_1 = a; bus.i_wdata_1 = d;
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'h00;
    rst = 1'b1;
    p0(0, 0, 3'b000, 32'h0, 32'h0);
    p1(0, 0, 3'b000, 32'h0, 32'h0);
    step(); step();
    // Store attempted during reset must not reach memory.
    p0(1, 1, 3'b010, 32'h10, 32'h1234_5678);
    pin("rst_gnt_0", S_GNT0, 0); pin("rst_wr_en", S_WREN, 0);
    step();
    p0(0, 0, 3'b000, 32'h0, 32'h0);
    pin("rst_rvalid_0", S_RV0, 0); pin("rst_rdata_0", S_RD0, 0);
    pin("rst_err_0", S_ERR0, 0); pin("rst_gnt_1", S_GNT1, 0);
    step();
    rst = 1'b0;

    // Port 1 stores 0xDEADBEEF at 0x10, then port 0 loads it back.
    p1(1, 1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    pin("sw_gnt_1", S_GNT1, 1); pin("sw_wr_en", S_WREN, 1);
    step();
    p1(0, 0, 3'b000, 32'h0, 32'h0);
    p0(1, 0, 3'b010, 32'h10, 32'h0);
    pin("lw_gnt_0", S_GNT0, 1); pin("sw_rvalid_1", S_RV1, 1); pin("sw_err_1", S_ERR1, 0);
    step();
    p0(0, 0, 3'b000, 32'h0, 32'h0);
    pin("lw_rvalid_0", S_RV0, 1); pin("lw_rdata_0", S_RD0, 32'hDEAD_BEEF); pin("lw_err_0", S_ERR0, 0);

    // Simultaneous requests: port 0 first, port 1 next cycle.
    step();
    p0(1, 0, 3'b010, 32'h10, 32'h0);
    p1(1, 0, 3'b100, 32'h10, 32'h0);
    pin("sim_gnt_0", S_GNT0, 1); pin("sim_gnt_1_wait", S_GNT1, 0);
    step();
    p0(0, 0, 3'b000, 32'h0, 32'h0);
    pin("sim_gnt_1", S_GNT1, 1); pin("sim_rvalid_0", S_RV0, 1); pin("sim_rvalid_1_low", S_RV1, 0);
    step();
    p1(0, 0, 3'b000, 32'h0, 32'h0);
    pin("sim_rvalid_1", S_RV1, 1); pin("sim_lbu_rdata_1", S_RD1, 32'h0000_00EF); pin("sim_rvalid_0_low", S_RV0, 0);

    // Illegal accesses back-to-back on port 1, with range boundary cases.
    step();
    p1(1, 1, 3'b001, 32'h3, 32'hFFFF);
    pin("sh_mis_gnt_1", S_GNT1, 1); pin("sh_mis_wr_en", S_WREN, 0); pin("sh_mis_rd_en", S_RDEN, 0);
    step();
    p1(1, 0, 3'b010, 32'h802, 32'h0);
    pin("sh_mis_rvalid", S_RV1, 1); pin("sh_mis_err", S_ERR1, 1); pin("sh_mis_rdata", S_RD1, 0);
    pin("lw_oor_rd_en", S_RDEN, 0);
    step();
    p1(1, 0, 3'b011, 32'h20, 32'h0);
    pin("lw_oor_rvalid", S_RV1, 1); pin("lw_oor_err", S_ERR1, 1); pin("lw_oor_rdata", S_RD1, 0);
    pin("f011_rd_en", S_RDEN, 0);
    step();
    p1(1, 0, 3'b010, 32'h7FC, 32'h0);
    pin("f011_rvalid", S_RV1, 1); pin("f011_err", S_ERR1, 1); pin("f011_rdata", S_RD1, 0);
    pin("lw_top_rd_en", S_RDEN, 1);
    step();
    p1(1, 0, 3'b100, 32'h800, 32'h0);
    pin("lw_top_rvalid", S_RV1, 1); pin("lw_top_err", S_ERR1, 0); pin("lbu_800_rd_en", S_RDEN, 0);
    step();
    p1(0, 0, 3'b000, 32'h0, 32'h0);
    pin("lbu_800_rvalid", S_RV1, 1); pin("lbu_800_err", S_ERR1, 1);

    // SB then LBU/LB from the same byte.
    step();
    p0(1, 1, 3'b000, 32'h21, 32'h0000_00A5);
    pin("sb_gnt_0", S_GNT0, 1); pin("sb_wr_en", S_WREN, 1); pin("sb_fun3", S_FUN3, 0);
    step();
    p0(1, 0, 3'b100, 32'h21, 32'h0);
    pin("lbu_rd_en", S_RDEN, 1); pin("sb_rvalid_0", S_RV0, 1); pin("sb_err_0", S_ERR0, 0);
    step();
    p0(1, 0, 3'b000, 32'h21, 32'h0);
    pin("lbu_rvalid_0", S_RV0, 1); pin("lbu_rdata_0", S_RD0, 32'h0000_00A5); pin("lbu_err_0", S_ERR0, 0);
    step();
    p0(0, 0, 3'b000, 32'h0, 32'h0);
    pin("lb_rvalid_0", S_RV0, 1); pin("lb_rdata_0", S_RD0, 32'hFFFF_FFA5);

    // Starvation: both request continuously; port 1 forced in on the 9th cycle.
    step();
    p0(1, 0, 3'b010, 32'h10, 32'h0);
    p1(1, 0, 3'b010, 32'h20, 32'h0);
    for (int k = 0; k < 11; k++) begin
      if (k == 0 || k == 7) begin pin("stv_gnt_0", S_GNT0, 1); pin("stv_gnt_1_wait", S_GNT1, 0); end
      if (k == 8) begin pin("stv_force_gnt_1", S_GNT1, 1); pin("stv_hold_gnt_0", S_GNT0, 0); end
      if (k == 9) begin
        pin("stv_resume_gnt_0", S_GNT0, 1); pin("stv_gnt_1_again", S_GNT1, 0);
        pin("stv_rvalid_1", S_RV1, 1); pin("stv_rdata_1", S_RD1, 32'h0000_A500);
      end
      step();
    end
    p0(0, 0, 3'b000, 32'h0, 32'h0);
    p1(0, 0, 3'b000, 32'h0, 32'h0);

    // Reset right after a port-0 acceptance; wait counter must restart from 0.
    step();
    p0(1, 0, 3'b010, 32'h10, 32'h0);
    p1(1, 0, 3'b010, 32'h20, 32'h0);
    pin("mrst_gnt_0", S_GNT0, 1);
    step();
    rst = 1'b1;
    pin("mrst_gnt_0_low", S_GNT0, 0); pin("mrst_gnt_1_low", S_GNT1, 0); pin("mrst_rd_en", S_RDEN, 0);
    step();
    rst = 1'b0;
    pin("mrst_rvalid_0", S_RV0, 0); pin("mrst_rdata_0", S_RD0, 0); pin("mrst_err_0", S_ERR0, 0);
    for (int k = 0; k < 9; k++) begin
      if (k == 0) pin("post_gnt_0", S_GNT0, 1);
      if (k == 7) pin("post_gnt_1_wait", S_GNT1, 0);
      if (k == 8) pin("post_force_gnt_1", S_GNT1, 1);
      step();
    end
    p0(0, 0, 3'b000, 32'h0, 32'h0);
    p1(0, 0, 3'b000, 32'h0, 32'h0);
    pin("post_rvalid_1", S_RV1, 1);
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access checker in front of the 2 KiB data memory. It shares the single memory port between the pipeline load/store unit (port 0) and a debug/DMA loader (port 1). Port 0 has fixed priority, and a wait counter stops port 1 from starving. Before any access reaches memory, the block checks funct3 legality, alignment and address range, then returns a registered response to the winning requester.

## Interface
Parameters:
- DEPTH_WORDS, 512: memory depth in 32-bit words; legal byte addresses are 0 to 4*DEPTH_WORDS-1.
- STARVE_LIMIT, 8: consecutive cycles port 1 may be denied before it is force-granted (range 1 to 255).

Ports (x = 0, 1):
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_x  in  1  request valid; held with its payload until accepted.
- i_we_x  in  1  1 = store, 0 = load.
- i_fun3_x  in  3  RV32I load/store funct3.
- i_addr_x  in  32  byte address.
- i_wdata_x  in  32  store data, LSB-aligned.
- o_gnt_x  out  1  combinational grant; a request is accepted at an edge where i_req_x and o_gnt_x are both 1.
- o_rvalid_x  out  1  one-cycle response pulse.
- o_rdata_x  out  32  registered load result; 0 for stores and errors.
- o_err_x  out  1  qualifies o_rvalid_x; the access was rejected.
- o_mem_rd_en, o_mem_wr_en  out  1  memory enables.
- o_mem_fun3  out  3  memory funct3.
- o_mem_addr  out  32  memory byte address.
- o_mem_wdata  out  32  memory write data.
- i_mem_rdata  in  32  memory read data (combinational read, already extended per funct3).

## Operation
- Grant rule, evaluated each cycle:
  - If starve_cnt == STARVE_LIMIT and i_req_1, port 1 is granted.
  - Otherwise, if i_req_0, port 0 is granted.
  - Otherwise, if i_req_1, port 1 is granted.
  - At most one grant is high. While i_rst is high, both grants are 0.
- starve_cnt (8 bit):
  - Cleared on reset, on any port-1 acceptance, and in any cycle with i_req_1 = 0.
  - Increments when i_req_1 = 1 and o_gnt_1 = 0.
  - Saturates at STARVE_LIMIT.
- Legality check on the granted payload; any failure sets err:
  - Load funct3 must be one of 000, 001, 010, 100, 101.
  - Store funct3 must be one of 000, 001, 010.
  - Halfword (funct3[1:0] = 01) requires addr[0] = 0.
  - Word (010) requires addr[1:0] = 0.
  - Address must satisfy addr < 4*DEPTH_WORDS.
- Memory drive (combinational):
  - Legal grant: o_mem_rd_en = ~we and o_mem_wr_en = we. fun3, addr and wdata are muxed from the winner.
  - No grant or illegal grant: both enables are 0, and fun3, addr and wdata are driven to 0.
- Response registers, loaded at each accepting edge for the winning port only:
  - rvalid <= 1.
  - err <= illegal.
  - rdata <= (legal load) ? i_mem_rdata : 0.
  - The non-winning port's rvalid is 0 the next cycle. With no acceptance, both rvalid are 0 the next cycle.
  - rdata holds its last value while rvalid is 0.
- Stores are committed by memory at the same edge that accepts them.

## Timing
- Reset values: o_rvalid_x = 0, o_err_x = 0, o_rdata_x = 0, starve_cnt = 0.
- Grant has zero-cycle latency, combinational from i_req_x and starve_cnt.
- A request accepted at edge N gives o_rvalid_x high during cycle N+1, exactly one cycle.
- Throughput is one accepted access per cycle; back-to-back acceptances on the same or alternating ports are allowed.
- Simultaneous requests go to port 0 unless the starve condition holds. The forced port-1 grant holds o_gnt_0 = 0 for that cycle, and port 0 stalls.
- Reset asserted mid-stream discards any response scheduled for the following cycle. No memory write occurs during reset cycles.
- Requesters must not change their payload while i_req_x = 1 and o_gnt_x = 0. Violations are undefined.

## Test plan
- Single load:
  - Stimulus: port 0 requests LW at address 0x10; i_mem_rdata = 0xDEADBEEF.
  - Response: o_gnt_0 = 1 in the same cycle; next cycle o_rvalid_0 = 1, o_rdata_0 = 0xDEADBEEF, o_err_0 = 0.
- Simultaneous requests:
  - Stimulus: both ports request in the same cycle; port 0 drops its request after acceptance.
  - Response: port 0 is granted first and port 1 the following cycle. Response pulses appear at cycles 1 and 2 on their respective ports.
- Starvation:
  - Stimulus: port 0 requests continuously and port 1 requests continuously with STARVE_LIMIT = 8.
  - Response: port 1 is granted on the 9th cycle with o_gnt_0 = 0. starve_cnt returns to 0, then port 0 resumes.
- Illegal accesses:
  - Stimulus: SH to address 0x3 on port 1; LW to address 0x802; load with funct3 = 011.
  - Response: each access is accepted, memory enables stay 0, and the next cycle shows o_rvalid = 1, o_err = 1, o_rdata = 0.
- Store then load:
  - Stimulus: SB 0xA5 to address 0x21, then LBU from address 0x21.
  - Response: o_mem_wr_en = 1 with o_mem_fun3 = 000 on the store cycle. The load returns o_rdata = 0x000000A5 with o_err = 0.
- Reset mid-stream:
  - Stimulus: i_rst asserted in the cycle after a port-0 acceptance.
  - Response: o_rvalid_0 = 0, o_rdata_0 = 0, both grants are 0 during reset, and starve_cnt = 0.
